dmem_byte_ctrl: RTL and testbench
=================================

DMEM_BYTE_CTRL -- requirements
Module: dmem_byte_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64: number of 32-bit words in the attached RAM.
REQ-002 SHALL have parameter IDX_BITS, default 6: word-index width, equal to log2(DEPTH_WORDS).
REQ-003 Clock: clk, input, 1 bit. One clock domain; all state changes on the rising edge of clk.
REQ-004 Reset: reset, input, 1 bit. Asynchronous, active-high.
REQ-005 SHALL have req_valid, input, 1 bit: a core access request is present.
REQ-006 SHALL have req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have req_byte, input, 1 bit: 1 = byte access (LDRB/STRB), 0 = word access.
REQ-008 SHALL have addr, input, 32 bits: byte address.
REQ-009 SHALL have wdata, input, 32 bits: store data; a byte store uses wdata[7:0] only.
REQ-010 SHALL have req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-011 SHALL have rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have rsp_err, output, 1 bit: the completed access was out of range.
REQ-013 SHALL have rdata, output, 32 bits: load result, valid only while rsp_valid is high.
REQ-014 SHALL have ram_addr, output, IDX_BITS bits: word index to the RAM.
REQ-015 SHALL have ram_we, output, 1 bit: RAM write enable.
REQ-016 SHALL have ram_wdata, output, 32 bits: RAM write word.
REQ-017 SHALL have ram_rdata, input, 32 bits: RAM read word, valid one cycle after ram_addr is presented.

Function
REQ-018 SHALL implement an FSM with states IDLE, RD, RDW, WR and ERR.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE with req_valid=1, the block SHALL latch addr, wdata, req_write and req_byte, then transition as follows:
- out of range (addr[31:IDX_BITS+2] != 0) -> ERR
- word store -> WR
- otherwise -> RD
REQ-021 req_valid SHALL be ignored in every state other than IDLE; there is no queueing.
REQ-022 RD SHALL drive ram_addr = latched addr[IDX_BITS+1:2] with ram_we=0, then go to RDW.
REQ-023 In RDW, a load SHALL assert rsp_valid and return to IDLE, with rdata as follows:
- word load: ram_rdata
- byte load: zero-extended byte, little-endian, selected by latched addr[1:0] (00 -> [7:0], 11 -> [31:24])
REQ-024 In RDW, a byte store SHALL register a merged word (ram_rdata with the addressed byte replaced by wdata[7:0]) and go to WR.
REQ-025 WR SHALL assert ram_we for exactly one cycle and assert rsp_valid in the same cycle, then return to IDLE.
- ram_wdata = latched wdata for a word store
- ram_wdata = merged word for a byte store
REQ-026 ERR SHALL assert rsp_valid and rsp_err for one cycle, with no RAM write, then return to IDLE.
REQ-027 Word accesses SHALL ignore addr[1:0]; they are forced aligned.
REQ-028 Latency SHALL be counted from the accept edge to the rsp_valid cycle:
- word store: 1 cycle
- load: 2 cycles
- byte store: 3 cycles
- out of range: 1 cycle
REQ-029 rsp_valid SHALL have no backpressure.
REQ-030 A new request SHALL be acceptable in the cycle after rsp_valid.
REQ-031 Outside rsp_valid, rdata SHALL be 0 and rsp_err SHALL be 0.
REQ-032 Outside WR, ram_we SHALL be 0 and ram_wdata SHALL be 0.

Reset
REQ-033 While reset is high, the FSM SHALL be in IDLE with:
- req_ready=1
- rsp_valid=0, rsp_err=0
- ram_we=0
- rdata=0, ram_addr=0, ram_wdata=0
- all latched fields cleared
REQ-034 Reset asserted mid-operation SHALL abort the access immediately.
- ram_we SHALL drop asynchronously.
- No partial write SHALL reach the RAM.
- No rsp_valid SHALL be issued for the aborted request.

Structure
REQ-035 Package dmem_pkg SHALL hold the state enum (IDLE, RD, RDW, WR, ERR) and the constants DEPTH_WORDS and IDX_BITS.
REQ-036 One sub-module, sram_sync, SHALL be used: a DEPTH_WORDS x 32 single-port RAM with registered read and write on clk.
- The bench SHALL instantiate sram_sync beside dmem_byte_ctrl.
- dmem_byte_ctrl SHALL NOT contain the storage array.

Verification
REQ-037 Word store, then word load, to addr 0x64:
- store wdata=0x00000007 -> rsp_valid 1 cycle after accept
- load -> rsp_valid 2 cycles after accept, rdata=0x00000007
REQ-038 Byte store over an existing word:
- RAM[0x60] = 0x11223344
- byte store addr 0x62, wdata=0xFFFFFFAB -> rsp_valid 3 cycles after accept
- following word load -> rdata=0x11AB3344
REQ-039 Byte loads from word 0xA1B2C3D4 at 0x10:
- addr 0x10 -> rdata=0x000000D4
- addr 0x13 -> rdata=0x000000A1
REQ-040 Out-of-range word store to addr 0x100:
- rsp_valid=1 and rsp_err=1 one cycle after accept
- ram_we never asserted
- RAM contents unchanged
REQ-041 Busy and back-to-back behaviour:
- req_valid held high through a load -> req_ready=0 in RD/RDW, second request ignored until IDLE
- back-to-back word stores -> one accepted every 2 cycles
REQ-042 Reset mid byte store:
- assert reset in RDW of a byte store to 0x62 -> ram_we never pulses, RAM[0x60] unchanged, no rsp_valid
- after reset -> req_ready=1

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states and RAM sizing for the data-memory byte controller
package dmem_pkg;
    localparam int DEPTH_WORDS = 64;
    localparam int IDX_BITS = 6;
    typedef enum logic [2:0] {IDLE, RD, RDW, WR, ERR} state_t;
endpackage

// File: rtl/sram_sync.sv
// sram_sync: single-port word RAM with registered read and write
module sram_sync import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = dmem_pkg::DEPTH_WORDS,
    parameter int IDX_BITS = dmem_pkg::IDX_BITS
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_BITS-1:0] addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    // write on enable; read returns the pre-write word one cycle later
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_byte_ctrl.sv
// dmem_byte_ctrl: sequences core word/byte loads and stores onto a word RAM
module dmem_byte_ctrl import dmem_pkg::*; #(
    parameter int DEPTH_WORDS = dmem_pkg::DEPTH_WORDS,
    parameter int IDX_BITS = dmem_pkg::IDX_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic                req_byte,
    input  logic [31:0]         addr,
    input  logic [31:0]         wdata,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [31:0]         rdata,
    output logic [IDX_BITS-1:0] ram_addr,
    output logic                ram_we,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata
);
    state_t state, state_nx;
    logic [IDX_BITS+1:0] addr_q;
    logic [31:0] wdata_q, merged_q, lane, merged_nx;
    logic write_q, byte_q, oor;
    logic [4:0] sh;

    assign oor = addr[31:2] >= 30'(DEPTH_WORDS);
    assign sh = {addr_q[1:0], 3'b000};
    assign lane = 32'hFF << sh;
    assign merged_nx = (ram_rdata & ~lane) | ({24'b0, wdata_q[7:0]} << sh);
    assign ram_addr = addr_q[IDX_BITS+1:2];

    // state register, request capture and read-modify-write merge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            byte_q <= 1'b0;
            merged_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                addr_q <= addr[IDX_BITS+1:0];
                wdata_q <= wdata;
                write_q <= req_write;
                byte_q <= req_byte;
            end
            if (state == RDW) merged_q <= merged_nx;
        end
    end

    // next state and state-decoded outputs; ram_we follows state so reset kills it at once
    always_comb begin
        state_nx = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err = 1'b0;
        rdata = '0;
        ram_we = 1'b0;
        ram_wdata = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = oor ? ERR : (req_write && !req_byte) ? WR : RD;
            end
            RD: state_nx = RDW;
            RDW: begin
                state_nx = write_q ? WR : IDLE;
                rsp_valid = !write_q;
                rdata = write_q ? '0 : byte_q ? {24'b0, 8'(ram_rdata >> sh)} : ram_rdata;
            end
            WR: begin
                ram_we = 1'b1;
                ram_wdata = byte_q ? merged_q : wdata_q;
                rsp_valid = 1'b1;
                state_nx = IDLE;
            end
            ERR: begin
                rsp_valid = 1'b1;
                rsp_err = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// tb_dmem_byte_ctrl: directed checks of the byte controller attached to sram_sync
module tb_dmem_byte_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic req_ready, rsp_valid, rsp_err, ram_we;
    logic [31:0] rdata, ram_wdata, ram_rdata;
    logic [5:0] ram_addr;
    int pass_cnt = 0, total = 0, we_cnt = 0, rv_cnt = 0;
    int lat;
    logic [31:0] rd;
    logic err;

    dmem_byte_ctrl #(.DEPTH_WORDS(64), .IDX_BITS(6)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_byte(req_byte), .addr(addr), .wdata(wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rdata(rdata), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    sram_sync #(.DEPTH_WORDS(64), .IDX_BITS(6)) ram (
        .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge ram_we) we_cnt++;
    always @(posedge rsp_valid) rv_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic access(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_byte = b;
        addr = a;
        wdata = d;
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        rd = 'x;
        err = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i;
                rd = rdata;
                err = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else pass_cnt++;
        total++;
        if ({rsp_valid, rsp_err, ram_we, rdata, ram_addr, ram_wdata} !== '0)
            $display("FAIL reset_outputs: got v=%b e=%b we=%b rd=%h ra=%h wd=%h want all 0", rsp_valid, rsp_err, ram_we, rdata, ram_addr, ram_wdata);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word;
        access(1'b1, 1'b0, 32'h64, 32'h7);
        total++; if (lat !== 1) $display("FAIL word_store_latency: got %0d want 1", lat); else pass_cnt++;
        total++; if (err !== 1'b0) $display("FAIL word_store_err: got %b want 0", err); else pass_cnt++;
        access(1'b0, 1'b0, 32'h64, 32'h0);
        total++; if (lat !== 2) $display("FAIL word_load_latency: got %0d want 2", lat); else pass_cnt++;
        total++; if (rd !== 32'h7) $display("FAIL word_load_data: got %h want 00000007", rd); else pass_cnt++;
    endtask

    task automatic test_byte_store;
        access(1'b1, 1'b0, 32'h60, 32'h11223344);
        access(1'b1, 1'b1, 32'h62, 32'hFFFFFFAB);
        total++; if (lat !== 3) $display("FAIL byte_store_latency: got %0d want 3", lat); else pass_cnt++;
        access(1'b0, 1'b0, 32'h60, 32'h0);
        total++; if (rd !== 32'h11AB3344) $display("FAIL byte_store_merge: got %h want 11ab3344", rd); else pass_cnt++;
    endtask

    task automatic test_byte_load;
        access(1'b1, 1'b0, 32'h10, 32'hA1B2C3D4);
        access(1'b0, 1'b1, 32'h10, 32'h0);
        total++; if (rd !== 32'hD4) $display("FAIL byte_load_0: got %h want 000000d4", rd); else pass_cnt++;
        total++; if (lat !== 2) $display("FAIL byte_load_latency: got %0d want 2", lat); else pass_cnt++;
        access(1'b0, 1'b1, 32'h13, 32'h0);
        total++; if (rd !== 32'hA1) $display("FAIL byte_load_3: got %h want 000000a1", rd); else pass_cnt++;
        access(1'b0, 1'b1, 32'h11, 32'h0);
        total++; if (rd !== 32'hC3) $display("FAIL byte_load_1: got %h want 000000c3", rd); else pass_cnt++;
        access(1'b0, 1'b0, 32'h13, 32'h0);
        total++; if (rd !== 32'hA1B2C3D4) $display("FAIL word_load_unaligned: got %h want a1b2c3d4", rd); else pass_cnt++;
    endtask

    task automatic test_out_of_range;
        int w0;
        access(1'b1, 1'b0, 32'h0, 32'h12345678);
        w0 = we_cnt;
        access(1'b1, 1'b0, 32'h100, 32'h55);
        total++; if (lat !== 1) $display("FAIL oor_latency: got %0d want 1", lat); else pass_cnt++;
        total++; if (err !== 1'b1) $display("FAIL oor_err: got %b want 1", err); else pass_cnt++;
        total++; if (we_cnt !== w0) $display("FAIL oor_no_write: got %0d writes want 0", we_cnt - w0); else pass_cnt++;
        @(negedge clk);
        total++; if (rsp_err !== 1'b0) $display("FAIL oor_err_clears: got %b want 0", rsp_err); else pass_cnt++;
        access(1'b0, 1'b0, 32'h0, 32'h0);
        total++; if (rd !== 32'h12345678) $display("FAIL oor_ram_unchanged: got %h want 12345678", rd); else pass_cnt++;
    endtask

    task automatic test_busy;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_byte = 1'b0;
        addr = 32'h64;
        @(posedge clk);
        #1;
        addr = 32'h10;
        req_write = 1'b1;
        wdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (req_ready !== 1'b0) $display("FAIL busy_ready_rd: got %b want 0", req_ready); else pass_cnt++;
        @(negedge clk);
        total++; if (req_ready !== 1'b0) $display("FAIL busy_ready_rdw: got %b want 0", req_ready); else pass_cnt++;
        total++;
        if (rsp_valid !== 1'b1 || rdata !== 32'h7) $display("FAIL busy_load_rsp: got v=%b rd=%h want v=1 rd=00000007", rsp_valid, rdata);
        else pass_cnt++;
        req_valid = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL busy_ready_idle: got %b want 1", req_ready); else pass_cnt++;
        access(1'b0, 1'b0, 32'h10, 32'h0);
        total++; if (rd !== 32'hA1B2C3D4) $display("FAIL busy_ignored_store: got %h want a1b2c3d4", rd); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int w0, r0;
        @(negedge clk);
        w0 = we_cnt;
        r0 = rv_cnt;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte = 1'b0;
        addr = 32'h20;
        wdata = 32'h99;
        repeat (8) @(negedge clk);
        req_valid = 1'b0;
        total++; if (we_cnt - w0 !== 4) $display("FAIL b2b_writes: got %0d want 4", we_cnt - w0); else pass_cnt++;
        total++; if (rv_cnt - r0 !== 4) $display("FAIL b2b_responses: got %0d want 4", rv_cnt - r0); else pass_cnt++;
        access(1'b0, 1'b0, 32'h20, 32'h0);
        total++; if (rd !== 32'h99) $display("FAIL b2b_data: got %h want 00000099", rd); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int w0, r0;
        @(negedge clk);
        w0 = we_cnt;
        r0 = rv_cnt;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte = 1'b1;
        addr = 32'h62;
        wdata = 32'hCD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (ram_we !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL midreset_outputs: got we=%b v=%b want 0 0", ram_we, rsp_valid); else pass_cnt++;
        total++; if (req_ready !== 1'b1) $display("FAIL midreset_ready_async: got %b want 1", req_ready); else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL midreset_ready_after: got %b want 1", req_ready); else pass_cnt++;
        total++; if (we_cnt !== w0) $display("FAIL midreset_no_write: got %0d writes want 0", we_cnt - w0); else pass_cnt++;
        total++; if (rv_cnt !== r0) $display("FAIL midreset_no_rsp: got %0d responses want 0", rv_cnt - r0); else pass_cnt++;
        access(1'b0, 1'b0, 32'h60, 32'h0);
        total++; if (rd !== 32'h11AB3344) $display("FAIL midreset_ram_unchanged: got %h want 11ab3344", rd); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte_store;
        test_byte_load;
        test_out_of_range;
        test_busy;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
